// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
//
// Sequencing controller for the 8259A interrupt-acknowledge and poll cycles.
// It watches the CPU's INTA# pulses and the RD# strobe and steps a registered
// control state machine. The strobes it produces feed the interrupt
// control-signal logic, the in-service register and the data-bus driver.
//
// Optional feature: define INTERRUPT_POLL_COMMAND_EN to include the POLL
// state, RD# edge detection and end_of_poll_command. When the macro is
// undefined, read_n and poll_command are ignored, POLL is unreachable and
// end_of_poll_command is tied low.
//
// Ports:
//   clock                        in   system clock, rising-edge active
//   reset_n                      in   asynchronous active-low reset
//   write_initial_command_word_1 in   ICW1 write strobe, aborts any sequence
//   interrupt_acknowledge_n      in   INTA#, synchronous to clock
//   read_n                       in   RD#, synchronous to clock
//   poll_command                 in   OCW3 poll request latched upstream
//   u8086_mode                   in   1 = two-pulse INTA, 0 = three-pulse INTA
//   control_state                out  registered current state
//   next_control_state           out  combinational next state
//   latch_in_service             out  pulse: latch winning IR into ISR
//   end_of_acknowledge_sequence  out  pulse: INTA sequence complete
//   end_of_poll_command          out  pulse: poll read complete
//   vector_output_enable         out  drive vector/poll byte onto data bus
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer #(
  parameter int ACK_STATE_WIDTH = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       write_initial_command_word_1,
  input  logic                       interrupt_acknowledge_n,
  input  logic                       read_n,
  input  logic                       poll_command,
  input  logic                       u8086_mode,
  output logic [ACK_STATE_WIDTH-1:0] control_state,
  output logic [ACK_STATE_WIDTH-1:0] next_control_state,
  output logic                       latch_in_service,
  output logic                       end_of_acknowledge_sequence,
  output logic                       end_of_poll_command,
  output logic                       vector_output_enable
);

  typedef enum logic [ACK_STATE_WIDTH-1:0] {
    CTL_READY = ACK_STATE_WIDTH'(3'b000),
    ACK1      = ACK_STATE_WIDTH'(3'b001),
    ACK2      = ACK_STATE_WIDTH'(3'b010),
    ACK3      = ACK_STATE_WIDTH'(3'b011),
    POLL      = ACK_STATE_WIDTH'(3'b100)
  } ctl_state_e;

  ctl_state_e state_q, state_d;
  logic       inta_prev_q, inta_prev_d;
  // Edges are only honoured once a clock edge has sampled the real input
  // after reset, so a line held low through reset does not look like a fall.
  logic       edge_arm_q, edge_arm_d;
  logic       inta_fall_s, inta_rise_s;

`ifdef INTERRUPT_POLL_COMMAND_EN
  logic       read_prev_q, read_prev_d;
  logic       read_fall_s, read_rise_s;
`else
  logic       unused_poll_inputs_s;
  assign unused_poll_inputs_s = read_n ^ poll_command;
`endif

  assign inta_fall_s = edge_arm_q & inta_prev_q & ~interrupt_acknowledge_n;
  assign inta_rise_s = edge_arm_q & ~inta_prev_q & interrupt_acknowledge_n;

`ifdef INTERRUPT_POLL_COMMAND_EN
  assign read_fall_s = edge_arm_q & read_prev_q & ~read_n;
  assign read_rise_s = edge_arm_q & ~read_prev_q & read_n;
`endif

  // State and edge-history registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CTL_READY;
      inta_prev_q <= 1'b1;
      edge_arm_q  <= 1'b0;
`ifdef INTERRUPT_POLL_COMMAND_EN
      read_prev_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      inta_prev_q <= inta_prev_d;
      edge_arm_q  <= edge_arm_d;
`ifdef INTERRUPT_POLL_COMMAND_EN
      read_prev_q <= read_prev_d;
`endif
    end
  end

  // Next-state logic; ICW1 overrides every transition.
  always_comb begin
    state_d     = state_q;
    inta_prev_d = interrupt_acknowledge_n;
    edge_arm_d  = 1'b1;
`ifdef INTERRUPT_POLL_COMMAND_EN
    read_prev_d = read_n;
`endif
    if (write_initial_command_word_1) begin
      state_d = CTL_READY;
    end else begin
      case (state_q)
        CTL_READY: begin
          // INTA wins over a simultaneous poll read.
          if (inta_fall_s) begin
            state_d = ACK1;
`ifdef INTERRUPT_POLL_COMMAND_EN
          end else if (read_fall_s && poll_command) begin
            state_d = POLL;
`endif
          end else begin
            state_d = CTL_READY;
          end
        end
        ACK1: begin
          if (inta_fall_s) begin
            state_d = ACK2;
          end else begin
            state_d = ACK1;
          end
        end
        ACK2: begin
          // Mode is sampled here, so a mid-sequence change only affects this exit.
          if (u8086_mode) begin
            if (inta_rise_s) begin
              state_d = CTL_READY;
            end else begin
              state_d = ACK2;
            end
          end else begin
            if (inta_fall_s) begin
              state_d = ACK3;
            end else begin
              state_d = ACK2;
            end
          end
        end
        ACK3: begin
          if (inta_rise_s) begin
            state_d = CTL_READY;
          end else begin
            state_d = ACK3;
          end
        end
`ifdef INTERRUPT_POLL_COMMAND_EN
        POLL: begin
          if (read_rise_s) begin
            state_d = CTL_READY;
          end else begin
            state_d = POLL;
          end
        end
`endif
        default: begin
          state_d = CTL_READY;
        end
      endcase
    end
  end

  // Strobes and bus enable decoded from current/next state.
  always_comb begin
    latch_in_service            = 1'b0;
    end_of_acknowledge_sequence = 1'b0;
    end_of_poll_command         = 1'b0;
    vector_output_enable        = 1'b0;

    if (state_q == CTL_READY) begin
`ifdef INTERRUPT_POLL_COMMAND_EN
      latch_in_service = (state_d == ACK1) || (state_d == POLL);
`else
      latch_in_service = (state_d == ACK1);
`endif
    end else begin
      latch_in_service = 1'b0;
    end

    if (((state_q == ACK2) || (state_q == ACK3)) && !write_initial_command_word_1) begin
      end_of_acknowledge_sequence = (state_d == CTL_READY);
    end else begin
      end_of_acknowledge_sequence = 1'b0;
    end

`ifdef INTERRUPT_POLL_COMMAND_EN
    if ((state_q == POLL) && !write_initial_command_word_1) begin
      end_of_poll_command = (state_d == CTL_READY);
    end else begin
      end_of_poll_command = 1'b0;
    end
`endif

    if ((state_q == ACK2) || (state_q == ACK3)) begin
      vector_output_enable = ~interrupt_acknowledge_n;
`ifdef INTERRUPT_POLL_COMMAND_EN
    end else if (state_q == POLL) begin
      vector_output_enable = ~read_n;
`endif
    end else begin
      vector_output_enable = 1'b0;
    end
  end

  assign control_state      = state_q;
  assign next_control_state = state_d;

endmodule
